// File: rtl/nand_gate_checker.sv
// nand_gate_checker
// -----------------
// Stimulus sequencer and result checker for the NAND-universal gate block.
// On an accepted start it drives the four {a,b} vectors 00, 01, 10, 11 in
// order. Each vector settles for SETTLE_CYCLES cycles and is then checked
// for one cycle against the Boolean expectation of all six gate outputs.
// At the end of the run it reports per-vector failures, a failing-vector
// count and a sticky per-output mismatch mask.
//
// Parameters:
//   SETTLE_CYCLES  cycles between applying a vector and sampling (1..15)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a 4-vector run; honoured only in IDLE
//   a, b       out  registered stimulus to the gate block
//   dut_out    in   gate outputs [5] a_not [4] b_not [3] ab_or
//                   [2] ab_and [1] ab_nand [0] ab_nor
//   busy       out  high from the cycle after start acceptance through CHECK
//   done       out  one-cycle pulse, results valid
//   pass       out  last completed run had no failing vector
//   err_count  out  failing vectors in the last run (0..4)
//   fail_mask  out  bit n set when vector n (n = {a,b}) failed
//   mismatch   out  sticky OR of (dut_out ^ expected) over the run
module nand_gate_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic [5:0] dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask,
    output logic [5:0] mismatch
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // The counter counts down to zero, so SETTLE spans exactly SETTLE_CYCLES.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_r;
    state_t     state_s;
    logic [3:0] cnt_r;
    logic [1:0] idx_r;
    logic       a_r;
    logic       b_r;
    logic       busy_r;
    logic       done_r;
    logic       pass_r;
    logic [2:0] err_count_r;
    logic [3:0] fail_mask_r;
    logic [5:0] mismatch_r;
    logic [5:0] diff_s;

    // Expected gate block outputs for a given input pair.
    function automatic logic [5:0] expected_outputs(input logic va, input logic vb);
        return {~va, ~vb, va | vb, va & vb, ~(va & vb), ~(va | vb)};
    endfunction

    // Per-output disagreement between the gate block and its expectation.
    always_comb begin
        diff_s = dut_out ^ expected_outputs(a_r, b_r);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_CHECK: begin
                if (idx_r == 2'd3) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Stimulus, settle counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= 4'd0;
            idx_r       <= 2'd0;
            a_r         <= 1'b0;
            b_r         <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            err_count_r <= 3'd0;
            fail_mask_r <= 4'd0;
            mismatch_r  <= 6'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r         <= 1'b0;
                        b_r         <= 1'b0;
                        idx_r       <= 2'd0;
                        cnt_r       <= SETTLE_LOAD;
                        busy_r      <= 1'b1;
                        pass_r      <= 1'b0;
                        err_count_r <= 3'd0;
                        fail_mask_r <= 4'd0;
                        mismatch_r  <= 6'd0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_CHECK: begin
                    mismatch_r <= mismatch_r | diff_s;
                    if (diff_s != 6'd0) begin
                        fail_mask_r[idx_r] <= 1'b1;
                        // At most four vectors fail, so the count never exceeds 4.
                        err_count_r        <= err_count_r + 3'd1;
                    end
                    if (idx_r != 2'd3) begin
                        idx_r      <= idx_r + 2'd1;
                        {a_r, b_r} <= idx_r + 2'd1;
                        cnt_r      <= SETTLE_LOAD;
                    end else begin
                        // fail_mask_r does not yet include this vector's verdict.
                        pass_r <= (fail_mask_r == 4'd0) && (diff_s == 6'd0);
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b0;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign a         = a_r;
    assign b         = b_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_count = err_count_r;
    assign fail_mask = fail_mask_r;
    assign mismatch  = mismatch_r;

endmodule

// File: tb/tb_nand_gate_checker.sv
// tb_nand_gate_checker
// --------------------
// Directed bench for nand_gate_checker. Two instances share clock and reset:
// dut2 (SETTLE_CYCLES=2) is fed by a behavioural gate block with selectable
// faults, dut1 (SETTLE_CYCLES=1) by a golden gate block.
module tb_nand_gate_checker;

    logic       clk;
    logic       rst_n;

    logic       start2;
    logic       a2, b2, busy2, done2, pass2;
    logic [2:0] err2;
    logic [3:0] fmask2;
    logic [5:0] mm2;
    logic [5:0] out2;
    int         mode;   // 0 golden, 1 ab_or stuck at 0, 2 ab_nand replaced by ab_and

    logic       start1;
    logic       a1, b1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [3:0] fmask1;
    logic [5:0] mm1;
    logic [5:0] out1;

    int checks   = 0;
    int failures = 0;

    nand_gate_checker #(.SETTLE_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
        .dut_out(out2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_mask(fmask2), .mismatch(mm2)
    );

    nand_gate_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .dut_out(out1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_mask(fmask1), .mismatch(mm1)
    );

    // Behavioural gate blocks
    always_comb begin
        out2 = {~a2, ~b2, a2 | b2, a2 & b2, ~(a2 & b2), ~(a2 | b2)};
        if (mode == 1) out2[3] = 1'b0;
        else if (mode == 2) out2[1] = a2 & b2;
        out1 = {~a1, ~b1, a1 | b1, a1 & b1, ~(a1 & b1), ~(a1 | b1)};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Enter in cycle 1 of an S=2 run; leave in the done cycle (13).
    task automatic walk2(input logic xp, input logic [2:0] xe,
                         input logic [3:0] xf, input logic [5:0] xm);
        for (int c = 1; c <= 12; c++) begin
            chk("vector_ab", {30'd0, a2, b2}, (c - 1) / 3);
            chk("busy_run", busy2, 1);
            chk("done_early", done2, 0);
            tick();
        end
        chk("done_pulse", done2, 1);
        chk("busy_done", busy2, 0);
        chk("pass", pass2, xp);
        chk("err_count", err2, xe);
        chk("fail_mask", fmask2, xf);
        chk("mismatch", mm2, xm);
    endtask

    task automatic start_pulse2();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        start2 = 1'b0;
        start1 = 1'b0;
        mode   = 0;
        #12;
        chk("rst_ab", {30'd0, a2, b2}, 0);
        chk("rst_busy_done_pass", {29'd0, busy2, done2, pass2}, 0);
        chk("rst_results", {19'd0, err2, fmask2, mm2}, 0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_busy", busy2, 0);

        // Golden run, S=2
        start_pulse2();
        walk2(1'b1, 3'd0, 4'b0000, 6'b000000);
        tick();
        chk("done_one_cycle", done2, 0);
        chk("ab_hold_11", {30'd0, a2, b2}, 3);
        chk("pass_hold", pass2, 1);
        tick();

        // ab_or stuck at 0
        mode = 1;
        start_pulse2();
        walk2(1'b0, 3'd3, 4'b1110, 6'b001000);
        tick();
        tick();

        // ab_nand replaced by ab_and
        mode = 2;
        start_pulse2();
        walk2(1'b0, 3'd4, 4'b1111, 6'b000010);
        tick();
        tick();

        // start held high: first run faulted, second golden
        mode   = 1;
        start2 = 1'b1;
        tick();
        walk2(1'b0, 3'd3, 4'b1110, 6'b001000);
        mode = 0;
        tick();
        chk("hold_idle_busy", busy2, 0);
        chk("hold_idle_done", done2, 0);
        chk("hold_results_kept", err2, 3);
        tick();
        chk("restart_busy", busy2, 1);
        chk("restart_err_cleared", err2, 0);
        chk("restart_mask_cleared", fmask2, 0);
        chk("restart_mm_cleared", mm2, 0);
        start2 = 1'b0;
        walk2(1'b1, 3'd0, 4'b0000, 6'b000000);
        tick();
        tick();

        // Reset during vector 2 settle
        mode = 1;
        start_pulse2();
        for (int c = 1; c < 7; c++) tick();
        chk("pre_rst_vector2", {30'd0, a2, b2}, 2);
        chk("pre_rst_mask", fmask2, 4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ab", {30'd0, a2, b2}, 0);
        chk("midrst_flags", {29'd0, busy2, done2, pass2}, 0);
        chk("midrst_results", {19'd0, err2, fmask2, mm2}, 0);
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            tick();
            chk("no_done_after_rst", {31'd0, done2}, 0);
            chk("idle_after_rst", {31'd0, busy2}, 0);
        end
        mode = 0;
        start_pulse2();
        walk2(1'b1, 3'd0, 4'b0000, 6'b000000);

        // Golden run, S=1
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk("s1_vector_ab", {30'd0, a1, b1}, (c - 1) / 2);
            chk("s1_done_early", done1, 0);
            tick();
        end
        chk("s1_done_pulse", done1, 1);
        chk("s1_pass", pass1, 1);
        chk("s1_results", {19'd0, err1, fmask1, mm1}, 0);
        tick();
        chk("s1_done_cleared", done1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
